bitcell_mem_responder: RTL and testbench



---
 rtl/bitcell_mem_pkg.sv | 6 +
 rtl/bitcell_mem_array.sv | 22 ++
 rtl/bitcell_mem_responder.sv | 75 +++++++
 tb/tb_bitcell_mem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bitcell_mem_pkg.sv
// bitcell_mem_pkg: shared FSM state type and request-type encodings
package bitcell_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/bitcell_mem_array.sv
// bitcell_mem_array: 2^ADDR_W x DATA_W word storage
//   clk, rst_n        : clock, asynchronous active-low clear of every word
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_i -> rdata_o   : combinational read port
module bitcell_mem_array #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/bitcell_mem_responder.sv
// bitcell_mem_responder: serialized multi-cycle read/write responder over a bitcell word array
//   clk, rst_n                  : clock, asynchronous active-low reset
//   valid_i/rw_i/addr_i/wdata_i : request (rw_i 1 = read, 0 = write)
//   ready_o                     : request can be accepted (IDLE)
//   resp_valid_o                : one-cycle completion pulse (RESP)
//   rdata_o                     : last read word, held across writes
module bitcell_mem_responder
  import bitcell_mem_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 4,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int CW = $clog2(ACC_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(ACC_CYC - 1);
  state_e            state_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              done;
  // the access completes on the edge where the counter reaches its last value
  assign done = state_q == ACCESS && cnt_q == LAST;
  bitcell_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (done && rw_q == RW_WRITE),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_o (mem_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          rw_q    <= rw_i;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          cnt_q   <= '0;
          state_q <= ACCESS;
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (done) begin
            state_q <= RESP;
            if (rw_q == RW_READ) rdata_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign ready_o      = state_q == IDLE;
  assign resp_valid_o = state_q == RESP;
  assign rdata_o      = rdata_q;
endmodule

// File: tb/tb_bitcell_mem_responder.sv
// tb_bitcell_mem_responder: table-driven and scoreboard checks of bitcell_mem_responder
module tb_bitcell_mem_responder;
  localparam int AC = 2;
  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic       junk;
    logic [3:0] exp;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic       rw_i = 1'b0;
  logic [1:0] addr_i = '0;
  logic [3:0] wdata_i = '0;
  logic       ready_o, resp_valid_o;
  logic [3:0] rdata_o;
  int pass = 0, total = 0, pulses = 0, cyc = 0;
  logic [3:0] exp_q[$];
  vec_t tbl[$];
  vec_t b2b[$];

  bitcell_mem_responder #(.ADDR_W(2), .DATA_W(4), .ACC_CYC(AC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .rw_i         (rw_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ready_o      (ready_o),
    .resp_valid_o (resp_valid_o),
    .rdata_o      (rdata_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    else pass++;
  endtask

  // scoreboard: every response pulse pops one expected rdata
  always @(negedge clk)
    if (rst_n && resp_valid_o) begin
      pulses++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL resp_unexpected got=1 exp=0 t=%0t", $time);
      end else chk("resp_rdata", rdata_o, exp_q.pop_front());
    end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("ready_timeout", ready_o, 1);
  endtask

  // one request with full cycle-by-cycle timing checks; junk drives an
  // ignored write (addr 1, data 5) while the block is busy
  task automatic req(input vec_t v);
    wait_ready();
    valid_i = 1'b1;
    rw_i = v.rw;
    addr_i = v.addr;
    wdata_i = v.wdata;
    exp_q.push_back(v.exp);
    @(negedge clk);
    valid_i = v.junk;
    rw_i = v.junk ? 1'b0 : 1'($urandom);
    addr_i = v.junk ? 2'd1 : 2'($urandom);
    wdata_i = v.junk ? 4'h5 : 4'($urandom);
    for (int j = 0; j <= AC + 1; j++) begin
      chk("ready_timing", ready_o, (j == AC + 1) ? 1 : 0);
      chk("resp_timing", resp_valid_o, (j == AC) ? 1 : 0);
      if (j == AC) valid_i = 1'b0;
      if (j <= AC) @(negedge clk);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [1:0] a, input logic [3:0] d,
                              input logic junk, input logic [3:0] exp);
    vec_t v;
    v.rw = rw; v.addr = a; v.wdata = d; v.junk = junk; v.exp = exp;
    return v;
  endfunction

  initial begin
    int p0, last;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, last;
    for (int a = 0; a < 4; a++) tbl.push_back(mk(1, 2'(a), 0, 0, 4'h0));
    tbl.push_back(mk(0, 2, 4'hA, 0, 4'h0));
    tbl.push_back(mk(1, 2, 4'h0, 0, 4'hA));
    tbl.push_back(mk(0, 0, 4'h7, 1, 4'hA));
    tbl.push_back(mk(1, 1, 4'h0, 0, 4'h0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h7));
    tbl.push_back(mk(0, 0, 4'h2, 0, 4'h7));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h2));
    for (int a = 0; a < 4; a++) b2b.push_back(mk(0, 2'(a), 4'(a + 1), 0, 4'h2));
    for (int a = 0; a < 4; a++) b2b.push_back(mk(1, 2'(a), 4'h0, 0, 4'(a + 1)));

    #12;
    chk("rst_ready", ready_o, 1);
    chk("rst_resp", resp_valid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) req(tbl[i]);

    p0 = pulses;
    last = 0;
    valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ready();
      if (i > 0) chk("b2b_gap", 4'(cyc - last), 4'(AC + 2));
      last = cyc;
      rw_i = b2b[i].rw;
      addr_i = b2b[i].addr;
      wdata_i = b2b[i].wdata;
      exp_q.push_back(b2b[i].exp);
      @(negedge clk);
    end
    valid_i = 1'b0;
    repeat (AC + 2) @(negedge clk);
    chk("b2b_pulses", 4'(pulses - p0), 4'd8);
    chk("b2b_drain", 4'(exp_q.size()), 4'd0);

    wait_ready();
    valid_i = 1'b1; rw_i = 1'b0; addr_i = 2'd3; wdata_i = 4'hF;
    @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready_o, 1);
    chk("abort_resp", resp_valid_o, 0);
    chk("abort_rdata", rdata_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    repeat (AC + 3) @(negedge clk);
    chk("abort_no_resp", 4'(pulses - p0), 4'd0);
    req(mk(1, 3, 0, 0, 4'h0));
    req(mk(1, 2, 0, 0, 4'h0));

    wait_ready();
    valid_i = 1'b1; rw_i = 1'b0; addr_i = 2'd1; wdata_i = 4'h9;
    exp_q.push_back(4'h0);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (AC) @(negedge clk);
    chk("resp_before_rst", resp_valid_o, 1);
    #2 rst_n = 1'b0;
    #1 chk("resp_async_drop", resp_valid_o, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req(mk(1, 1, 0, 0, 4'h0));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
